// File: rtl/riscv_core_muldiv_unit.sv
// ---------------------------------------------------------------------------
// riscv_core_muldiv_unit
//
// RV64 M-extension execution unit. Multiplies finish in a single cycle (the
// full 128-bit product is formed from the registered operands). Divides use a
// radix-2 restoring divider on operand magnitudes, producing one quotient bit
// per cycle (64 iterations, 32 for W-variants). A final FIX cycle applies sign
// correction and selects quotient or remainder. Divide-by-zero and signed
// overflow skip the iterative divider and go straight to FIX.
//
// Ports
//   i_clk                rising-edge clock
//   i_rst_n              asynchronous active-low reset
//   i_muldiv_valid       operation request
//   i_muldiv_alucontrol  [2:0] MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU; bit 3 ignored
//   i_muldiv_word        RV64 W-variant select
//   i_muldiv_rs1/rs2     operands a / b
//   i_muldiv_rd          destination tag
//   i_muldiv_flush       abort in-flight op; blocks accept while high
//   o_muldiv_ready       unit idle
//   o_muldiv_done        one-cycle result-valid pulse
//   o_muldiv_result      result, held until the next done
//   o_muldiv_rd          tag of the operation that produced o_muldiv_result
// ---------------------------------------------------------------------------
module riscv_core_muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_muldiv_valid,
    input  logic [3:0]  i_muldiv_alucontrol,
    input  logic        i_muldiv_word,
    input  logic [63:0] i_muldiv_rs1,
    input  logic [63:0] i_muldiv_rs2,
    input  logic [4:0]  i_muldiv_rd,
    input  logic        i_muldiv_flush,
    output logic        o_muldiv_ready,
    output logic        o_muldiv_done,
    output logic [63:0] o_muldiv_result,
    output logic [4:0]  o_muldiv_rd
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] neg_if(input logic c, input logic [63:0] v);
        return c ? (~v + 64'd1) : v;
    endfunction

    function automatic logic signed [129:0] ext130(input logic [63:0] v, input logic s);
        return {{66{s & v[63]}}, v};
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        word_q, word_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] dvs_q, dvs_d;
    logic [63:0] res_q, res_d;
    logic [4:0]  rdo_q, rdo_d;

    // Operand conditioning at accept time
    logic        in_unsigned;
    logic [63:0] in_a_eff, in_b_eff, in_min_neg, in_mag_a, in_mag_b;
    logic        in_div_zero, in_overflow;

    always_comb begin
        in_unsigned = i_muldiv_alucontrol[0];
        if (i_muldiv_word) begin
            in_a_eff   = in_unsigned ? {32'd0, i_muldiv_rs1[31:0]} : sext32(i_muldiv_rs1[31:0]);
            in_b_eff   = in_unsigned ? {32'd0, i_muldiv_rs2[31:0]} : sext32(i_muldiv_rs2[31:0]);
            in_min_neg = 64'hFFFF_FFFF_8000_0000;
        end else begin
            in_a_eff   = i_muldiv_rs1;
            in_b_eff   = i_muldiv_rs2;
            in_min_neg = 64'h8000_0000_0000_0000;
        end
        in_div_zero = (in_b_eff == 64'd0);
        in_overflow = !in_unsigned && (in_a_eff == in_min_neg) && (in_b_eff == '1);
        in_mag_a    = neg_if(!in_unsigned && in_a_eff[63], in_a_eff);
        in_mag_b    = neg_if(!in_unsigned && in_b_eff[63], in_b_eff);
    end

    // Multiplier: operands widened with per-op signedness so one signed
    // multiply covers MULH, MULHSU and MULHU.
    logic signed [129:0] mul_a_w, mul_b_w, mul_prod_w;
    logic [63:0]         mul_res;

    always_comb begin
        mul_a_w    = ext130(a_q, (op_q == 3'd1) || (op_q == 3'd2));
        mul_b_w    = ext130(b_q, (op_q == 3'd1));
        mul_prod_w = mul_a_w * mul_b_w;
        if (word_q)
            mul_res = sext32(mul_prod_w[31:0]);
        else if (op_q[1:0] == 2'b00)
            mul_res = mul_prod_w[63:0];
        else
            mul_res = mul_prod_w[127:64];
    end

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    logic [64:0] div_shift, div_sub;
    logic        div_ge;

    always_comb begin
        div_shift = {rem_q, quo_q[63]};
        div_sub   = div_shift - {1'b0, dvs_q};
        div_ge    = (div_shift >= {1'b0, dvs_q});
    end

    // Sign correction and result selection
    logic        fix_signed;
    logic [63:0] fix_quo, fix_rem, fix_sel, fix_res;

    always_comb begin
        fix_signed = !op_q[0];
        if (dz_q) begin
            fix_quo = '1;
            fix_rem = a_q;
        end else if (ovf_q) begin
            fix_quo = a_q;
            fix_rem = 64'd0;
        end else begin
            fix_quo = neg_if(fix_signed && (a_q[63] ^ b_q[63]), quo_q);
            fix_rem = neg_if(fix_signed && a_q[63], rem_q);
        end
        fix_sel = op_q[1] ? fix_rem : fix_quo;
        fix_res = word_q ? sext32(fix_sel[31:0]) : fix_sel;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        word_d  = word_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        rdo_d   = rdo_q;

        if (i_muldiv_flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_muldiv_valid && !i_muldiv_flush) begin
                        op_d   = i_muldiv_alucontrol[2:0];
                        word_d = i_muldiv_word;
                        a_d    = in_a_eff;
                        b_d    = in_b_eff;
                        rd_d   = i_muldiv_rd;
                        dz_d   = i_muldiv_alucontrol[2] && in_div_zero;
                        ovf_d  = i_muldiv_alucontrol[2] && in_overflow;
                        cnt_d  = i_muldiv_word ? 7'd32 : 7'd64;
                        // W-variants run 32 steps, so park the dividend in the upper half
                        quo_d  = i_muldiv_word ? {in_mag_a[31:0], 32'd0} : in_mag_a;
                        rem_d  = 64'd0;
                        dvs_d  = in_mag_b;
                        if (!i_muldiv_alucontrol[2])
                            state_d = S_MUL;
                        else if (in_div_zero || in_overflow)
                            state_d = S_FIX;
                        else
                            state_d = S_DIV;
                    end
                end
                S_MUL: begin
                    res_d   = mul_res;
                    rdo_d   = rd_q;
                    state_d = S_DONE;
                end
                S_DIV: begin
                    rem_d = div_ge ? div_sub[63:0] : div_shift[63:0];
                    quo_d = {quo_q[62:0], div_ge};
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        state_d = S_FIX;
                end
                S_FIX: begin
                    res_d   = fix_res;
                    rdo_d   = rd_q;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            word_q  <= 1'b0;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            rd_q    <= 5'd0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 7'd0;
            quo_q   <= 64'd0;
            rem_q   <= 64'd0;
            dvs_q   <= 64'd0;
            res_q   <= 64'd0;
            rdo_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            word_q  <= word_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

    assign o_muldiv_ready  = (state_q == S_IDLE);
    // A flush arriving in DONE withdraws the pulse in the same cycle
    assign o_muldiv_done   = (state_q == S_DONE) && !i_muldiv_flush;
    assign o_muldiv_result = res_q;
    assign o_muldiv_rd     = rdo_q;

    // Bits that are structurally never needed: opcode bit 3, product guard
    // bits, and the divider's carry bit (always zero in the selected branch).
    logic unused_bits;
    assign unused_bits = ^{i_muldiv_alucontrol[3], mul_prod_w[129:128], div_sub[64], div_shift[64]};

endmodule

// File: tb/tb_riscv_core_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_core_muldiv_unit
//
// Directed corner cases plus randomized operations for the M-extension unit,
// compared against an arithmetic reference model (plain SV * / % on the
// architectural rules, with MULH variants derived from the unsigned product).
// ---------------------------------------------------------------------------
module tb_riscv_core_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [3:0]  alu;
    logic        word;
    logic [63:0] rs1, rs2;
    logic [4:0]  rd;
    logic        flush;
    logic        ready, done;
    logic [63:0] result;
    logic [4:0]  rd_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_core_muldiv_unit dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_muldiv_valid      (valid),
        .i_muldiv_alucontrol (alu),
        .i_muldiv_word       (word),
        .i_muldiv_rs1        (rs1),
        .i_muldiv_rs2        (rs2),
        .i_muldiv_rd         (rd),
        .i_muldiv_flush      (flush),
        .o_muldiv_ready      (ready),
        .o_muldiv_done       (done),
        .o_muldiv_result     (result),
        .o_muldiv_rd         (rd_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural reference
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       pu;
        logic [63:0]        r;
        logic signed [63:0] sa, sb;
        logic [31:0]        a32, b32, r32;
        logic signed [31:0] sa32, sb32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa32 = a32;
            sb32 = b32;
            if (!op[2])
                r32 = a32 * b32;
            else if (b32 == 32'd0)
                r32 = op[1] ? a32 : 32'hFFFF_FFFF;
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = op[1] ? 32'd0 : a32;
            else if (op == 3'd4)
                r32 = sa32 / sb32;
            else if (op == 3'd5)
                r32 = a32 / b32;
            else if (op == 3'd6)
                r32 = sa32 % sb32;
            else
                r32 = a32 % b32;
            return sx32(r32);
        end
        sa = a;
        sb = b;
        pu = {64'd0, a} * {64'd0, b};
        case (op)
            3'd0: r = pu[63:0];
            3'd1: r = pu[127:64] - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
            3'd2: r = pu[127:64] - (a[63] ? b : 64'd0);
            3'd3: r = pu[127:64];
            default: begin
                if (b == 64'd0)
                    r = op[1] ? a : '1;
                else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)
                    r = op[1] ? 64'd0 : a;
                else if (op == 3'd4)
                    r = sa / sb;
                else if (op == 3'd5)
                    r = a / b;
                else if (op == 3'd6)
                    r = sa % sb;
                else
                    r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic int spec_latency(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        logic dz, ovf;
        if (!op[2]) return 2;
        if (w) begin
            dz  = (b[31:0] == 32'd0);
            ovf = !op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        end else begin
            dz  = (b == 64'd0);
            ovf = !op[0] && a == 64'h8000_0000_0000_0000 && b == '1;
        end
        if (dz || ovf) return 2;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_8000_0000;
            5: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge, idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] t, input logic [63:0] exp);
        int lat;
        bit got;
        check({tag, "/ready"}, 64'(ready), 64'd1);
        valid = 1'b1;
        alu   = {1'($urandom), op};
        word  = w;
        rs1   = a;
        rs2   = b;
        rd    = t;
        @(posedge clk);
        #1;
        valid = 1'b0;
        alu   = 4'($urandom);
        word  = 1'($urandom);
        rs1   = {$urandom, $urandom};
        rs2   = {$urandom, $urandom};
        rd    = 5'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = done;
        end
        check({tag, "/latency"}, 64'(lat + 1), 64'(spec_latency(op, w, a, b)));
        check({tag, "/result"}, result, exp);
        check({tag, "/rd"}, 64'(rd_o), 64'(t));
        @(posedge clk);
        @(negedge clk);
        check({tag, "/pulse_end"}, 64'(done), 64'd0);
        check({tag, "/ready_after"}, 64'(ready), 64'd1);
        check({tag, "/hold"}, result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;

        rst_n = 1'b1;
        valid = 1'b0;
        alu   = 4'd0;
        word  = 1'b0;
        rs1   = 64'd0;
        rs2   = 64'd0;
        rd    = 5'd0;
        flush = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/ready", 64'(ready), 64'd1);
        check("reset/done", 64'(done), 64'd0);
        check("reset/result", result, 64'd0);
        check("reset/rd", 64'(rd_o), 64'd0);
        rst_n = 1'b1;

        // first accept on the first rising edge after release
        run_op("mul_first", 3'd0, 1'b0, 64'd6, 64'd7, 5'd3, 64'd42);

        run_op("mulhu_ones", 3'd3, 1'b0, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulh_ones",  3'd1, 1'b0, '1, '1, 5'd5, 64'h0);
        run_op("mul_ones",   3'd0, 1'b0, '1, '1, 5'd6, 64'h1);
        run_op("mulhsu",     3'd2, 1'b0, '1, 64'd2, 5'd7, '1);
        run_op("mulw",       3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhuw",     3'd3, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op("div_m7_2",   3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_m7_2",   3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 5'd12, 64'd14);
        run_op("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 5'd13, 64'd2);

        run_op("div_by0",    3'd4, 1'b0, 64'd5, 64'd0, 5'd14, '1);
        run_op("rem_by0",    3'd6, 1'b0, 64'd5, 64'd0, 5'd15, 64'd5);
        run_op("div_ovf",    3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd16, 64'h8000_0000_0000_0000);
        run_op("rem_ovf",    3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd17, 64'd0);

        run_op("divw_ovf",   3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd18, 64'hFFFF_FFFF_8000_0000);
        run_op("divuw",      3'd5, 1'b1, '1, 64'd2, 5'd19, 64'h0000_0000_7FFF_FFFF);
        run_op("remw_m7",    3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd20, '1);
        run_op("remuw_by0",  3'd7, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 5'd21,
               64'hFFFF_FFFF_9ABC_DEF0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom);
            w  = 1'($urandom);
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d_op%0d_w%0d", i, op, w), op, w, a, b, 5'($urandom),
                   ref_model(op, w, a, b));
        end

        // Flush of a divide at T+10, then a multiply accepted right after
        valid = 1'b1;
        alu   = 4'd4;
        word  = 1'b0;
        rs1   = 64'd1000;
        rs2   = 64'd3;
        rd    = 5'd9;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush/busy", 64'(ready), 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush/ready", 64'(ready), 64'd1);
        check("flush/no_done", 64'(done), 64'd0);
        run_op("flush_mul", 3'd0, 1'b0, 64'd3, 64'd4, 5'd22, 64'd12);

        // Flush while idle blocks the accept
        valid = 1'b1;
        flush = 1'b1;
        alu   = 4'd0;
        rs1   = 64'd5;
        rs2   = 64'd5;
        rd    = 5'd1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || !ready) cnt++;
        end
        check("idle_flush/blocked", 64'(cnt), 64'd0);
        check("idle_flush/result", result, 64'd12);

        // Flush during DONE suppresses the pulse
        valid = 1'b1;
        alu   = 4'd0;
        rs1   = 64'd7;
        rs2   = 64'd8;
        rd    = 5'd2;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        #1;
        check("done_flush/pulse", 64'(done), 64'd0);
        check("done_flush/result", result, 64'd56);
        check("done_flush/rd", 64'(rd_o), 64'd2);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("done_flush/ready", 64'(ready), 64'd1);
        check("done_flush/after", 64'(done), 64'd0);

        // Asynchronous reset in the middle of a divide
        valid = 1'b1;
        alu   = 4'd4;
        rs1   = 64'd1000;
        rs2   = 64'd3;
        rd    = 5'd11;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset/ready", 64'(ready), 64'd1);
        check("midreset/done", 64'(done), 64'd0);
        check("midreset/result", result, 64'd0);
        check("midreset/rd", 64'(rd_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("midreset/no_done", 64'(cnt), 64'd0);
        run_op("post_reset_divu", 3'd5, 1'b0, 64'd1000, 64'd3, 5'd23, 64'd333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
